// File: rtl/ds_stream_pkg.sv
// ds_stream_pkg: register map, control bit indices and reset helpers for ds_sample_streamer.
package ds_stream_pkg;
  localparam int ADDR_SAMPLE = 0;
  localparam int ADDR_RATE   = 1;
  localparam int ADDR_CTRL   = 2;
  localparam int ADDR_WMARK  = 3;
  localparam int CTRL_RUN    = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_CLR    = 2;
  function automatic logic [31:0] midscale(input int bits);
    return 32'd1 << (bits - 1);
  endfunction
endpackage

// File: rtl/ds_host_write_port.sv
// ds_host_write_port: synchronises the byte-phase strobe and assembles 16-bit host writes.
module ds_host_write_port #(
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           data_in,
  input  logic [ADDR_BITS-1:0] addr_in,
  input  logic                 data_part_in,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [15:0]          wr_data
);
  logic [2:0] sync;
  logic [7:0] low;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 3'b111;
      low  <= '0;
    end else begin
      sync <= {sync[1:0], data_part_in};
      if (sync[2] && !sync[1]) low <= data_in;
    end
  end
  // sync[1] is the synchronised strobe, sync[2] its previous value
  assign wr_en   = sync[1] && !sync[2];
  assign wr_addr = addr_in;
  assign wr_data = {data_in, low};
endmodule

// File: rtl/ds_sample_streamer.sv
// ds_sample_streamer: host-fed sample FIFO released to the modulator every RATE+1 ticks.
// Optional DS_STREAM_WATERMARK_EN adds the WMARK register and the refill_req output.
module ds_sample_streamer
  import ds_stream_pkg::*;
#(
  parameter int SAMPLE_BITS = 16,
  parameter int DEPTH       = 8,
  parameter int ADDR_BITS   = 3,
  parameter int RATE_BITS   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               data_in,
  input  logic [ADDR_BITS-1:0]     addr_in,
  input  logic                     data_part_in,
  input  logic                     tick,
  output logic [SAMPLE_BITS-1:0]   sample_out,
  output logic                     sample_strobe,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     running
`ifdef DS_STREAM_WATERMARK_EN
  , output logic                   refill_req
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [SAMPLE_BITS-1:0] MID = SAMPLE_BITS'(midscale(SAMPLE_BITS));
  logic                   wr_en;
  logic [ADDR_BITS-1:0]   wr_addr;
  logic [15:0]            wr_data;
  logic [SAMPLE_BITS-1:0] wr_sample;
  logic [SAMPLE_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]          wptr, rptr;
  logic [RATE_BITS-1:0]   rate, cnt;
  logic                   ctrl_wr, flush, clr, push, pop_due, do_pop, do_push, run_nx, full, empty;
  logic [LW-1:0]          level_nx;
  ds_host_write_port #(.ADDR_BITS(ADDR_BITS)) u_port (
    .clk, .rst_n, .data_in, .addr_in, .data_part_in,
    .wr_en, .wr_addr, .wr_data
  );
  // host words are left-aligned into the sample width
  generate
    if (SAMPLE_BITS == 16) begin : g_eq
      assign wr_sample = wr_data;
    end else if (SAMPLE_BITS > 16) begin : g_wide
      assign wr_sample = {wr_data, {(SAMPLE_BITS-16){1'b0}}};
    end else begin : g_narrow
      assign wr_sample = wr_data[15 -: SAMPLE_BITS];
    end
  endgenerate
  always_comb begin
    ctrl_wr  = wr_en && wr_addr == ADDR_BITS'(ADDR_CTRL);
    flush    = ctrl_wr && wr_data[CTRL_FLUSH];
    clr      = ctrl_wr && wr_data[CTRL_CLR];
    push     = wr_en && wr_addr == ADDR_BITS'(ADDR_SAMPLE);
    full     = fifo_level == LW'(DEPTH);
    empty    = fifo_level == '0;
    pop_due  = running && tick && cnt == '0;
    do_pop   = pop_due && !empty && !flush;
    do_push  = push && (!full || do_pop) && !flush;
    level_nx = flush ? '0 : fifo_level + LW'(do_push) - LW'(do_pop);
    run_nx   = ctrl_wr ? wr_data[CTRL_RUN] : running;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out    <= MID;
      sample_strobe <= 1'b0;
      fifo_level    <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      running       <= 1'b0;
      rate          <= '0;
      cnt           <= '0;
      wptr          <= '0;
      rptr          <= '0;
    end else begin
      running       <= run_nx;
      fifo_level    <= level_nx;
      sample_strobe <= do_pop;
      if (do_pop) sample_out <= mem[rptr];
      wptr      <= flush ? '0 : wptr + PW'(do_push);
      rptr      <= flush ? '0 : rptr + PW'(do_pop);
      overflow  <= (overflow && !clr) || (push && full && !do_pop && !flush);
      underflow <= (underflow && !clr) || (pop_due && empty && !flush);
      cnt       <= !run_nx ? '0 : !tick ? cnt : cnt == '0 ? rate : cnt - 1'b1;
      if (wr_en && wr_addr == ADDR_BITS'(ADDR_RATE)) rate <= RATE_BITS'(wr_data);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr_sample;
  end
`ifdef DS_STREAM_WATERMARK_EN
  logic [LW-1:0] wmark, wmark_nx;
  assign wmark_nx = (wr_en && wr_addr == ADDR_BITS'(ADDR_WMARK)) ? wr_data[LW-1:0] : wmark;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wmark      <= LW'(DEPTH / 2);
      refill_req <= 1'b0;
    end else begin
      wmark      <= wmark_nx;
      refill_req <= run_nx && level_nx <= wmark_nx;
    end
  end
`endif
endmodule

// File: tb/tb_ds_sample_streamer.sv
// tb_ds_sample_streamer: randomized scoreboard bench against a queue-based model of the streamer.
module tb_ds_sample_streamer;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  logic          clk = 0, rst_n = 0, data_part_in = 1, tick = 0;
  logic [7:0]    data_in = 0;
  logic [2:0]    addr_in = 0;
  logic [15:0]   sample_out;
  logic          sample_strobe, overflow, underflow, running;
  logic [LW-1:0] fifo_level;
`ifdef DS_STREAM_WATERMARK_EN
  logic          refill_req;
`endif
  ds_sample_streamer #(.SAMPLE_BITS(16), .DEPTH(DEPTH), .ADDR_BITS(3), .RATE_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr_in(addr_in),
    .data_part_in(data_part_in), .tick(tick), .sample_out(sample_out),
    .sample_strobe(sample_strobe), .fifo_level(fifo_level), .overflow(overflow),
    .underflow(underflow), .running(running)
`ifdef DS_STREAM_WATERMARK_EN
    , .refill_req(refill_req)
`endif
  );
  always #5 clk = ~clk;
  int          checks = 0, failures = 0;
  logic [15:0] exp_q[$], m_q[$];
  logic [15:0] m_sample;
  bit          m_run, m_ovf, m_unf;
  int          m_rate, m_cnt;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && sample_strobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL strobe_unexpected: got sample %0h expected no strobe", sample_out);
      end else chk("strobe_sample", sample_out, exp_q.pop_front());
    end
  end
  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_sample = 16'h8000;
    m_run = 0; m_ovf = 0; m_unf = 0; m_rate = 0; m_cnt = 0;
  endtask
  task automatic host_write(input int addr, input logic [15:0] word);
    @(posedge clk); #1;
    data_in = word[7:0]; data_part_in = 0;
    repeat (4) @(posedge clk);
    #1;
    data_in = word[15:8]; addr_in = 3'(addr); data_part_in = 1;
    repeat (4) @(posedge clk);
    #1;
    if (addr == 0) begin
      if (m_q.size() < DEPTH) m_q.push_back(word); else m_ovf = 1;
    end else if (addr == 1) m_rate = word;
    else if (addr == 2) begin
      if (word[1]) m_q.delete();
      if (word[2]) begin m_ovf = 0; m_unf = 0; end
      m_run = word[0];
      if (!m_run) m_cnt = 0;
    end
  endtask
  task automatic model_tick();
    if (m_run) begin
      if (m_cnt == 0) begin
        m_cnt = m_rate;
        if (m_q.size() > 0) begin
          m_sample = m_q.pop_front();
          exp_q.push_back(m_sample);
        end else m_unf = 1;
      end else m_cnt--;
    end
  endtask
  task automatic do_tick();
    model_tick();
    @(posedge clk); #1 tick = 1;
    @(posedge clk); #1 tick = 0;
  endtask
  task automatic check_state(input string name);
    @(negedge clk);
    chk({name, "_level"}, fifo_level, m_q.size());
    chk({name, "_sample"}, sample_out, m_sample);
    chk({name, "_ovf"}, overflow, m_ovf);
    chk({name, "_unf"}, underflow, m_unf);
    chk({name, "_run"}, running, m_run);
  endtask
  // host push lands on the same clock edge as a tick while the FIFO is full
  task automatic coincide(input logic [15:0] word);
    model_tick();
    m_q.push_back(word);
    @(posedge clk); #1;
    data_in = word[7:0]; data_part_in = 0;
    repeat (4) @(posedge clk);
    #1;
    data_in = word[15:8]; addr_in = 3'd0; data_part_in = 1;
    repeat (2) @(posedge clk);
    #1 tick = 1;
    @(posedge clk); #1 tick = 0;
    repeat (2) @(posedge clk);
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_sample", sample_out, 16'h8000);
    chk("reset_level", fifo_level, 0);
    chk("reset_strobe", sample_strobe, 0);
    chk("reset_flags", {overflow, underflow, running}, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (20) do_tick();
    check_state("idle");
    host_write(0, 16'h1234);
    host_write(0, 16'h5678);
    host_write(1, 16'd2);
    host_write(2, 16'd1);
    for (int i = 1; i <= 6; i++) begin
      do_tick();
      check_state($sformatf("seq_t%0d", i));
    end
    do_tick();
    @(negedge clk);
    chk("seq_t7_underflow", underflow, 1);
    chk("seq_t7_hold", sample_out, 16'h5678);
    host_write(2, 16'd4);
    for (int i = 0; i <= DEPTH; i++) host_write(0, 16'($urandom));
    check_state("overflow");
    chk("overflow_level_full", fifo_level, DEPTH);
    host_write(1, 16'd0);
    host_write(2, 16'd1);
    repeat (DEPTH) do_tick();
    check_state("drained");
    host_write(2, 16'd5);
    for (int i = 0; i < DEPTH; i++) host_write(0, 16'($urandom));
    coincide(16'hBEEF);
    check_state("coincide");
    chk("coincide_no_ovf", overflow, 0);
    host_write(2, 16'd3);
    check_state("flush");
    do_tick();
    for (int i = 0; i < 3; i++) host_write(0, 16'($urandom));
    check_state("preflush");
    host_write(2, 16'd7);
    check_state("flush_clr");
    host_write(1, 16'($urandom_range(0, 2)));
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) host_write(0, 16'($urandom)); else do_tick();
      @(negedge clk);
      chk($sformatf("rand_level_%0d", i), fifo_level, m_q.size());
      chk($sformatf("rand_sample_%0d", i), sample_out, m_sample);
    end
    check_state("rand_end");
    host_write(0, 16'hAAAA);
    host_write(0, 16'h5555);
    @(negedge clk); #2 rst_n = 0;
    #1;
    chk("async_sample", sample_out, 16'h8000);
    chk("async_level", fifo_level, 0);
    chk("async_flags", {overflow, underflow, running, sample_strobe}, 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1;
`ifdef DS_STREAM_WATERMARK_EN
    host_write(3, 16'd2);
    host_write(2, 16'd1);
    host_write(0, 16'h0101);
    host_write(0, 16'h0202);
    @(negedge clk);
    chk("wmark_level2", refill_req, 1);
    host_write(0, 16'h0303);
    @(negedge clk);
    chk("wmark_level3", refill_req, 0);
`endif
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
